mult_div_unit: RTL

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 16 +
 rtl/mult_div_unit_if.sv | 20 ++
 rtl/mdu_negate.sv | 8 +
 rtl/mult_div_unit.sv | 106 ++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// mdu_pkg: shared operation and FSM encodings for the multiply/divide unit.
package mdu_pkg;
    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } mdu_state_e;
endpackage

// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request, HI/LO write and result signals of the multiply/divide unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
    logic             start;
    mdu_pkg::mdu_op_e op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, a, b, hi_we, lo_we, wdata,
                    input  busy, done, div_zero, hi, lo);
    modport slave  (input  start, op, a, b, hi_we, lo_we, wdata,
                    output busy, done, div_zero, hi, lo);
endinterface

// File: rtl/mdu_negate.sv
// mdu_negate: combinational conditional two's-complement negate.
module mdu_negate #(parameter int W = 32) (
    input  logic [W-1:0] a_i,
    input  logic         neg_i,
    output logic [W-1:0] y_o
);
    assign y_o = neg_i ? (~a_i + 1'b1) : a_i;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers, one bit per cycle.
module mult_div_unit import mdu_pkg::*; #(parameter int WIDTH = 32) (
    input logic             clk,
    input logic             rst_n,
    mult_div_unit_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d, dz_q, dz_d;
    logic [WIDTH-1:0] wh_q, wh_d, wl_q, wl_d, md_q, md_d, hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] a_mag, b_mag, quot, rem;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]   sum, rem_sh, diff;
    logic             sgn_op, is_div_op, b_zero, wr_ok;

    assign sgn_op    = ~bus.op[0];
    assign is_div_op = bus.op[1];
    assign b_zero    = (bus.b == '0);
    assign wr_ok     = (state_q == S_IDLE) || (state_q == S_DONE);

    mdu_negate #(.W(WIDTH))   u_neg_a (.a_i(bus.a), .neg_i(sgn_op & bus.a[WIDTH-1]), .y_o(a_mag));
    mdu_negate #(.W(WIDTH))   u_neg_b (.a_i(bus.b), .neg_i(sgn_op & bus.b[WIDTH-1]), .y_o(b_mag));
    mdu_negate #(.W(2*WIDTH)) u_neg_p (.a_i({wh_q, wl_q}), .neg_i(neg_res_q), .y_o(prod));
    mdu_negate #(.W(WIDTH))   u_neg_q (.a_i(wl_q), .neg_i(neg_res_q), .y_o(quot));
    mdu_negate #(.W(WIDTH))   u_neg_r (.a_i(wh_q), .neg_i(neg_rem_q), .y_o(rem));

    // wl holds multiplier/dividend bits, wh the partial product/remainder, md the multiplicand/divisor
    assign sum    = {1'b0, wh_q} + (wl_q[0] ? {1'b0, md_q} : '0);
    assign rem_sh = {wh_q, wl_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, md_q};

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        wh_d      = wh_q;
        wl_d      = wl_q;
        md_d      = md_q;
        hi_d      = (wr_ok && bus.hi_we) ? bus.wdata : hi_q;
        lo_d      = (wr_ok && bus.lo_we) ? bus.wdata : lo_q;
        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d   = (is_div_op && b_zero) ? S_DONE : S_CALC;
                cnt_d     = CW'(WIDTH);
                is_div_d  = is_div_op;
                neg_res_d = sgn_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                neg_rem_d = sgn_op & bus.a[WIDTH-1];
                dz_d      = is_div_op && b_zero;
                wh_d      = '0;
                wl_d      = a_mag;
                md_d      = b_mag;
            end
            S_CALC: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = (cnt_q == CW'(1)) ? S_FIX : S_CALC;
                wh_d    = is_div_q ? (diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
                wl_d    = is_div_q ? {wl_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], wl_q[WIDTH-1:1]};
            end
            S_FIX: begin
                {hi_d, lo_d} = is_div_q ? {rem, quot} : prod;
                state_d      = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
            wh_q      <= '0;
            wl_q      <= '0;
            md_q      <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
            wh_q      <= wh_d;
            wl_q      <= wl_d;
            md_q      <= md_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy     = (state_q == S_CALC) || (state_q == S_FIX);
    assign bus.done     = (state_q == S_DONE);
    assign bus.div_zero = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule
